// File: rtl/match_row_sched.sv
// Purpose : packs the reference-row phase stream into cache windows over two
//           ping-pong banks and hands each completed bank to the match core.
// Latency : window write 1 cycle after its last beat; bank READY 2 cycles after
//           the row's last beat; core_en 1 cycle after the bank turns READY.
// Backpr. : ref_tready is low while the bank being filled is READY or BUSY.
//           It rises the cycle after row_done releases that bank.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ref_t*                reference phase beat stream (sample 0 in LSBs)
//   cache_wr_*            one window write per completed window
//   core_bank / core_en   bank currently owned by the match core
//   phase_buf_empty_i     phase FIFO empty flag
//   core_buf_empty        phase FIFO empty flag as seen by the core
//   row_done              core finished the row (vld & tlast)
//   row_err               one-cycle pulse on a short or long reference row
//   row_cnt               completed matched rows, wraps
module match_row_sched #(
    parameter int ROW_SIZE   = 1280,
    parameter int WIN_SIZE   = 128,
    parameter int BEAT_SIZE  = 8,
    parameter int DATA_WIDTH = 16,
    localparam int NWIN      = ROW_SIZE / WIN_SIZE,
    localparam int BPW       = WIN_SIZE / BEAT_SIZE,
    localparam int AW        = (NWIN > 1) ? $clog2(NWIN) : 1,
    localparam int BIW       = (BPW > 1) ? $clog2(BPW) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [BEAT_SIZE*DATA_WIDTH-1:0]  ref_tdata,
    input  logic                             ref_tvalid,
    output logic                             ref_tready,
    input  logic                             ref_tlast,
    output logic                             cache_wr_en,
    output logic                             cache_wr_bank,
    output logic [AW-1:0]                    cache_wr_addr,
    output logic [WIN_SIZE*DATA_WIDTH-1:0]   cache_wr_data,
    output logic                             core_bank,
    output logic                             core_en,
    input  logic                             phase_buf_empty_i,
    output logic                             core_buf_empty,
    input  logic                             row_done,
    output logic                             row_err,
    output logic [15:0]                      row_cnt
);

    localparam int BEAT_W = BEAT_SIZE * DATA_WIDTH;
    localparam int WIN_W  = WIN_SIZE * DATA_WIDTH;

    localparam logic [1:0] B_EMPTY = 2'd0;
    localparam logic [1:0] B_READY = 2'd1;
    localparam logic [1:0] B_BUSY  = 2'd2;

    localparam logic F_FILL  = 1'b0;
    localparam logic F_DRAIN = 1'b1;

    localparam logic M_IDLE = 1'b0;
    localparam logic M_RUN  = 1'b1;

    logic [1:0][1:0]  bank_st;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             fill_st;
    logic             match_st;
    logic [BIW-1:0]   beat_idx;   // beat position inside the current window
    logic [AW-1:0]    win_idx;    // window position inside the current row
    logic [WIN_W-1:0] asm_q;
    logic [WIN_W-1:0] win_next;
    logic             commit_pend;
    logic             hs;
    logic             win_end;
    logic             row_end;

    assign ref_tready     = (fill_st == F_DRAIN) || (bank_st[wr_ptr] == B_EMPTY);
    assign hs             = ref_tvalid & ref_tready;
    assign win_end        = (beat_idx == BIW'(BPW - 1));
    assign row_end        = win_end && (win_idx == AW'(NWIN - 1));
    assign core_buf_empty = phase_buf_empty_i | ~core_en;

    // Assembly buffer with the current beat merged into its lane, so the
    // window write can carry the last beat without an extra cycle.
    always_comb begin
        win_next = asm_q;
        for (int i = 0; i < BPW; i++) begin
            if (beat_idx == BIW'(i)) begin
                win_next[i*BEAT_W +: BEAT_W] = ref_tdata;
            end
        end
    end

    // Fill side: window assembly, cache writes, row framing checks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_st       <= F_FILL;
            wr_ptr        <= 1'b0;
            beat_idx      <= '0;
            win_idx       <= '0;
            asm_q         <= '0;
            commit_pend   <= 1'b0;
            cache_wr_en   <= 1'b0;
            cache_wr_bank <= 1'b0;
            cache_wr_addr <= '0;
            cache_wr_data <= '0;
            row_err       <= 1'b0;
        end else begin
            cache_wr_en <= 1'b0;
            row_err     <= 1'b0;
            commit_pend <= 1'b0;
            if (hs) begin
                if (fill_st == F_DRAIN) begin
                    if (ref_tlast) begin
                        fill_st <= F_FILL;
                    end
                end else begin
                    asm_q <= win_next;
                    if (win_end) begin
                        cache_wr_en   <= 1'b1;
                        cache_wr_bank <= wr_ptr;
                        cache_wr_addr <= win_idx;
                        cache_wr_data <= win_next;
                    end
                    if (row_end) begin
                        beat_idx <= '0;
                        win_idx  <= '0;
                        if (ref_tlast) begin
                            // wr_ptr moves now so the next row's first beat
                            // targets the other bank; the filled bank turns
                            // READY one cycle later, after its final write.
                            commit_pend <= 1'b1;
                            wr_ptr      <= ~wr_ptr;
                        end else begin
                            row_err <= 1'b1;
                            fill_st <= F_DRAIN;
                        end
                    end else if (ref_tlast) begin
                        // Short row: bank stays EMPTY, partial windows are
                        // simply overwritten by the next row.
                        row_err  <= 1'b1;
                        beat_idx <= '0;
                        win_idx  <= '0;
                    end else if (win_end) begin
                        beat_idx <= '0;
                        win_idx  <= win_idx + AW'(1);
                    end else begin
                        beat_idx <= beat_idx + BIW'(1);
                    end
                end
            end
        end
    end

    // Match side and bank ownership. A commit always targets an EMPTY bank
    // while start/release touch READY/BUSY banks, so the updates never
    // collide on the same bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_st   <= '0;
            rd_ptr    <= 1'b0;
            match_st  <= M_IDLE;
            core_en   <= 1'b0;
            core_bank <= 1'b0;
            row_cnt   <= '0;
        end else begin
            if (commit_pend) begin
                bank_st[cache_wr_bank] <= B_READY;
            end
            case (match_st)
                M_IDLE: begin
                    // Only rd_ptr is examined: rows are matched in load order.
                    if (bank_st[rd_ptr] == B_READY) begin
                        bank_st[rd_ptr] <= B_BUSY;
                        core_bank       <= rd_ptr;
                        core_en         <= 1'b1;
                        match_st        <= M_RUN;
                    end
                end
                default: begin
                    if (row_done) begin
                        bank_st[core_bank] <= B_EMPTY;
                        core_en            <= 1'b0;
                        rd_ptr             <= ~rd_ptr;
                        row_cnt            <= row_cnt + 16'd1;
                        match_st           <= M_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
